serializer: RTL and testbench

SERIALIZER -- requirements
Module: serializer

---
 rtl/serializer.sv | 68 ++++++
 tb/tb_serializer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/serializer.sv
// serializer: shifts a parallel word out LSB first, then pulses ser_done for one clock.
module serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  ser_en,
    output logic                  ser_done,
    output logic                  ser_data
);
    localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t                state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic [CW-1:0]         cnt_q;
    logic                  done_q;
    logic                  data_q;
    assign shift_d  = shift_q >> 1;
    assign ser_done = done_q;
    assign ser_data = data_q;
    // data_q always mirrors shift_q[0] while in SHIFT, so it is loaded with the next bit one edge early
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            data_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    data_q <= 1'b0;
                    if (ser_en) begin
                        shift_q <= P_DATA;
                        cnt_q   <= '0;
                        data_q  <= P_DATA[0];
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_q <= shift_d;
                    if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                        cnt_q   <= '0;
                        data_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q  <= cnt_q + CW'(1);
                        data_q <= shift_d[0];
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    data_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    data_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serializer.sv
// tb_serializer: directed checks of the serializer frame timing, reset and input isolation.
module tb_serializer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       ser_en = 1'b0;
    logic       ser_done;
    logic       ser_data;
    int         n_chk = 0;
    int         n_fail = 0;

    serializer #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .P_DATA(P_DATA), .ser_en(ser_en),
        .ser_done(ser_done), .ser_data(ser_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at the negedge just after the load edge; checks 8 bits, the done cycle and one idle cycle.
    task automatic frame(input string tag, input logic [7:0] exp_word, input logic [7:0] new_data);
        for (int i = 0; i < 8; i++) begin
            if (i == 0) P_DATA = new_data;
            chk({tag, "_bit"}, {31'd0, ser_data}, {31'd0, exp_word[i]});
            chk({tag, "_nodone"}, {31'd0, ser_done}, 32'd0);
            @(negedge clk);
        end
        chk({tag, "_done"}, {31'd0, ser_done}, 32'd1);
        chk({tag, "_done_data"}, {31'd0, ser_data}, 32'd0);
        @(negedge clk);
        chk({tag, "_idle_done"}, {31'd0, ser_done}, 32'd0);
        chk({tag, "_idle_data"}, {31'd0, ser_data}, 32'd0);
    endtask

    task automatic load(input logic [7:0] d);
        P_DATA = d;
        ser_en = 1'b1;
        @(negedge clk);
        ser_en = 1'b0;
    endtask

    initial begin
        logic [7:0] w;
        // reset held with a pending request
        ser_en = 1'b1;
        P_DATA = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            chk("rst_done", {31'd0, ser_done}, 32'd0);
            chk("rst_data", {31'd0, ser_data}, 32'd0);
        end
        ser_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {30'd0, ser_done, ser_data}, 32'd0);

        load(8'h8F);
        frame("single", 8'h8F, 8'h8F);

        // held request: 10-clock period, two full frames
        w = 8'h9E;
        P_DATA = w;
        ser_en = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            int m;
            m = k % 10;
            if (m < 8) begin
                chk("held_bit", {31'd0, ser_data}, {31'd0, w[m]});
                chk("held_nodone", {31'd0, ser_done}, 32'd0);
            end else if (m == 8) begin
                chk("held_done", {31'd0, ser_done}, 32'd1);
                chk("held_done_data", {31'd0, ser_data}, 32'd0);
            end else begin
                chk("held_idle", {30'd0, ser_done, ser_data}, 32'd0);
            end
            @(negedge clk);
        end
        ser_en = 1'b0;
        repeat (10) @(negedge clk);

        // P_DATA changes during SHIFT must not alter the frame
        load(8'h8F);
        frame("midchange", 8'h8F, 8'h00);

        // reset during the 4th bit
        load(8'h8F);
        repeat (3) @(negedge clk);
        chk("abort_bit3", {31'd0, ser_data}, 32'd1);
        #1 rst = 1'b0;
        #1 chk("abort_async", {30'd0, ser_done, ser_data}, 32'd0);
        @(negedge clk);
        chk("abort_held", {30'd0, ser_done, ser_data}, 32'd0);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_idle", {30'd0, ser_done, ser_data}, 32'd0);
        end
        load(8'hA5);
        frame("after_rst", 8'hA5, 8'hA5);

        // ser_en only during DONE must not reload
        load(8'h8F);
        repeat (8) @(negedge clk);
        chk("den_done", {31'd0, ser_done}, 32'd1);
        P_DATA = 8'hFF;
        ser_en = 1'b1;
        @(negedge clk);
        ser_en = 1'b0;
        repeat (4) begin
            chk("den_idle", {30'd0, ser_done, ser_data}, 32'd0);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
